// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

   localparam int XLEN_DEF = 32;
   localparam int BE_W_DEF = XLEN_DEF / 8;

   // One memory transaction is in flight in every state except IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      DROP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (IF)
// and data access (MEM). Data requests win by default because the MEM-stage
// instruction is older. A taken branch (flush) cancels an outstanding fetch;
// the memory still completes it but the response is swallowed in DROP.
// Optional macro ARB_FAIR_EN: after MAX_D_BURST consecutive data grants made
// while a fetch waits, the next arbitration with both pending goes to the fetch.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int MAX_D_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_valid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_be,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_valid,
   output logic [XLEN-1:0]   d_rdata,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ready,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   arb_state_t state;
   logic       fetch_turn;
   logic       grant_fetch;
   logic       grant_data;

`ifdef ARB_FAIR_EN
   localparam int CNT_W = $clog2(MAX_D_BURST + 1);

   logic [CNT_W-1:0] burst_cnt;

   assign fetch_turn = (burst_cnt == CNT_W'(MAX_D_BURST));

   // Count data grants that overtook a waiting fetch; saturates at MAX_D_BURST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt <= '0;
      end else if (state == IDLE) begin
         if (grant_fetch || !if_req) begin
            burst_cnt <= '0;
         end else if (grant_data && !fetch_turn) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_burst_cfg;

   assign fetch_turn       = 1'b0;
   assign unused_burst_cfg = ^MAX_D_BURST;
`endif

   // A flushed fetch is never granted; data wins unless the fairness turn is up.
   assign grant_fetch = if_req && !flush && (!d_req || fetch_turn);
   assign grant_data  = d_req && !grant_fetch;

   // Transaction sequencer; memory attributes are latched at grant and held until mem_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_fetch) begin
                  state     <= FETCH;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= '1;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end else if (grant_data) begin
                  state     <= DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_be    <= d_be;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end else if (flush) begin
                  state <= DROP;
               end
            end
            DATA, DROP: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Completion pulses are combinational so the requester sees data in the ready cycle.
   assign if_valid  = (state == FETCH) && mem_ready && !flush;
   assign d_valid   = (state == DATA) && mem_ready;
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign stall_if  = if_req && !if_valid;
   assign stall_mem = d_req && !d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a variable-latency memory model.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        flush = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        stall_if;
   logic        stall_mem;

   typedef struct {
      logic        is_data;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          mem_lat = 1;
   int          lat_cnt = 0;
   logic [31:0] mem_arr [logic [31:0]];
   bit          stream_mode = 1'b0;
   int          stream_left = 0;

   unified_mem_arbiter #(.XLEN(32), .MAX_D_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return 32'h0;
   endfunction

   // Memory model: mem_ready pulses once mem_req has been high for mem_lat cycles.
   initial forever begin
      logic [31:0] cur;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (!rst_n || !mem_req) begin
         lat_cnt = 0;
      end else if (lat_cnt == mem_lat) begin
         cur = mem_read(mem_addr);
         mem_rdata = cur;
         mem_ready = 1'b1;
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_arr[mem_addr] = cur;
         end
         lat_cnt = 0;
      end else begin
         lat_cnt++;
      end
   end

   // Requesters: drop a request in the cycle its completion is seen.
   initial forever begin
      @(negedge clk);
      if (stream_mode) begin
         if (if_valid || d_valid) begin
            stream_left--;
            if (stream_left == 0) begin
               if_req = 1'b0;
               d_req = 1'b0;
               stream_mode = 1'b0;
            end
         end
      end else begin
         if (if_valid) if_req = 1'b0;
         if (d_valid) d_req = 1'b0;
      end
   end

   // Monitor: every completion pulse must match the oldest expected response.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (if_valid || d_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {30'h0, d_valid, if_valid}, 32'h0);
         end else begin
            e = sb.pop_front();
            check("valid_kind", {31'h0, d_valid}, {31'h0, e.is_data});
            if (e.chk_data)
               check(e.is_data ? "d_rdata" : "if_rdata", e.is_data ? d_rdata : if_rdata, e.data);
            $display("txn %s rdata=%h t=%0t", d_valid ? "DATA " : "FETCH", mem_rdata, $time);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input logic is_data, input logic chk, input logic [31:0] data);
      exp_t e;
      e.is_data = is_data;
      e.chk_data = chk;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while ((if_req || d_req || mem_req) && n < 300) begin
         tick();
         n++;
      end
      check(name, {31'h0, n >= 300}, 32'h0);
      tick();
   endtask

   task automatic data_access(input logic we, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] exp_rd);
      d_we = we; d_addr = a; d_be = be; d_wdata = wd; d_req = 1'b1;
      push(1'b1, !we, exp_rd);
      wait_quiet("data_access_timeout");
   endtask

   initial begin
      mem_arr[32'h100] = 32'h00500093;
      mem_arr[32'h300] = 32'h12345678;
      mem_arr[32'h400] = 32'hCAFEF00D;

      // Reset state
      tick(3);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", {28'h0, mem_be}, 32'h0);
      check("rst_valids", {30'h0, d_valid, if_valid}, 32'h0);
      rst_n = 1'b1;
      tick(2);

      // Fetch 0x100, ready 3 cycles after mem_req
      mem_lat = 3;
      if_addr = 32'h100; if_req = 1'b1;
      push(1'b0, 1'b1, 32'h00500093);
      #1 check("stall_if_req", {31'h0, stall_if}, 32'h1);
      tick();
      check("fetch_grant_req", {31'h0, mem_req}, 32'h1);
      check("fetch_grant_we", {31'h0, mem_we}, 32'h0);
      check("fetch_grant_be", {28'h0, mem_be}, 32'hF);
      check("fetch_grant_addr", mem_addr, 32'h100);
      check("stall_if_wait", {31'h0, stall_if}, 32'h1);
      tick(3);
      check("fetch_valid_cycle", {31'h0, if_valid}, 32'h1);
      check("stall_if_release", {31'h0, stall_if}, 32'h0);
      tick();
      check("fetch_idle_after", {31'h0, mem_req}, 32'h0);
      wait_quiet("fetch_timeout");

      // Simultaneous fetch and store: data first, fetch after one IDLE cycle
      mem_lat = 1;
      if_addr = 32'h100; if_req = 1'b1;
      d_we = 1'b1; d_addr = 32'h200; d_be = 4'hF; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
      push(1'b1, 1'b0, 32'h0);
      push(1'b0, 1'b1, 32'h00500093);
      tick();
      check("prio_we", {31'h0, mem_we}, 32'h1);
      check("prio_addr", mem_addr, 32'h200);
      check("prio_wdata", mem_wdata, 32'hDEADBEEF);
      check("prio_stall_if", {31'h0, stall_if}, 32'h1);
      tick(2);
      check("prio_idle_gap", {31'h0, mem_req}, 32'h0);
      tick();
      check("prio_fetch_req", {31'h0, mem_req}, 32'h1);
      check("prio_fetch_addr", mem_addr, 32'h100);
      wait_quiet("prio_timeout");

      // Partial store then readback
      data_access(1'b1, 32'h200, 4'b0011, 32'h11223344, 32'h0);
      data_access(1'b0, 32'h200, 4'hF, 32'h0, 32'hDEAD3344);

      // Flush one cycle before mem_ready: dropped, then refetch 0x300
      mem_lat = 3;
      if_addr = 32'h100; if_req = 1'b1;
      tick(3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if_addr = 32'h300;
      push(1'b0, 1'b1, 32'h12345678);
      check("drop_holds_req", {31'h0, mem_req}, 32'h1);
      check("drop_no_valid", {31'h0, if_valid}, 32'h0);
      tick();
      check("drop_to_idle", {31'h0, mem_req}, 32'h0);
      tick();
      check("refetch_addr", mem_addr, 32'h300);
      wait_quiet("refetch_timeout");

      // Flush coincident with mem_ready in FETCH
      mem_lat = 1;
      if_addr = 32'h100; if_req = 1'b1;
      tick(2);
      flush = 1'b1;
      #1 check("flush_ready_no_valid", {31'h0, if_valid}, 32'h0);
      tick();
      flush = 1'b0; if_req = 1'b0;
      check("flush_ready_idle", {31'h0, mem_req}, 32'h0);
      tick();
      check("flush_ready_no_regrant", {31'h0, mem_req}, 32'h0);

      // if_req, d_req and flush together; flush held through DATA
      mem_lat = 2;
      flush = 1'b1;
      if_addr = 32'h100; if_req = 1'b1;
      d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF; d_req = 1'b1;
      push(1'b1, 1'b1, 32'hCAFEF00D);
      tick();
      check("flush_data_addr", mem_addr, 32'h400);
      begin
         int n = 0;
         while (d_req && n < 50) begin tick(); n++; end
         check("flush_data_timeout", {31'h0, n >= 50}, 32'h0);
      end
      flush = 1'b0; if_req = 1'b0;
      tick(2);
      check("flush_no_fetch", {31'h0, mem_req}, 32'h0);

      // Asynchronous reset during DATA, then re-grant
      mem_lat = 5;
      d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
      push(1'b1, 1'b1, 32'hCAFEF00D);
      tick(2);
      check("pre_reset_req", {31'h0, mem_req}, 32'h1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_req", {31'h0, mem_req}, 32'h0);
      check("async_rst_valid", {31'h0, d_valid}, 32'h0);
      check("async_rst_stall", {31'h0, stall_mem}, 32'h1);
      tick();
      rst_n = 1'b1;
      tick();
      check("regrant_req", {31'h0, mem_req}, 32'h1);
      wait_quiet("regrant_timeout");

      // Continuous d_req and if_req: fairness pattern or starvation
      mem_lat = 1;
      for (int i = 0; i < 10; i++) begin
`ifdef ARB_FAIR_EN
         if (i % 5 == 4) push(1'b0, 1'b1, 32'h00500093);
         else push(1'b1, 1'b1, 32'hCAFEF00D);
`else
         push(1'b1, 1'b1, 32'hCAFEF00D);
`endif
      end
      stream_left = 10;
      stream_mode = 1'b1;
      if_addr = 32'h100; if_req = 1'b1;
      d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
      wait_quiet("stream_timeout");

      check("scoreboard_drained", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
